// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler
//   Time-multiplexes four digit values onto a single seven-segment decoder.
//   Writes go to a shadow bank. A commit request copies shadow to the active
//   bank only at the frame edge, so a frame is never shown half old and half new.
//
// Ports
//   clk_i               system clock, rising edge
//   rst_ni              asynchronous active-low reset
//   wr_en_i             write digit_data_i/dot_data_i into shadow[wr_addr_i]
//   wr_addr_i [1:0]     shadow digit index
//   digit_data_i        digit value for the addressed cell
//   dot_data_i          dot for the addressed cell (1 = dot off)
//   commit_i            one-cycle request to copy shadow->active at next frame edge
//   wr_ack_o            one-cycle pulse the cycle after a write
//   commit_pending_o    commit requested, copy not yet done
//   frame_tick_o        one-cycle pulse at the start of each new frame
//   binary_o            value of the scanned digit
//   segment_o [1:0]     index of the scanned cell
//   dot_o               dot of the scanned digit

module display_scan_scheduler #(
  parameter int DATA_W      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [1:0]        wr_addr_i,
  input  logic [DATA_W-1:0] digit_data_i,
  input  logic              dot_data_i,
  input  logic              commit_i,
  output logic              wr_ack_o,
  output logic              commit_pending_o,
  output logic              frame_tick_o,
  output logic [DATA_W-1:0] binary_o,
  output logic [1:0]        segment_o,
  output logic              dot_o
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFRESH_DIV - 1);

  // cnt_q holds the cycles still to go for the current digit. It starts at
  // REFRESH_DIV-1 and counts down, so reaching zero is the last cycle of a digit.
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [1:0]                   ptr_q, ptr_d;
  logic [3:0][DATA_W-1:0]       shadow_val_q, shadow_val_d;
  logic [3:0]                   shadow_dot_q, shadow_dot_d;
  logic [3:0][DATA_W-1:0]       active_val_q, active_val_d;
  logic [3:0]                   active_dot_q, active_dot_d;
  logic                         pending_q, pending_d;
  logic                         wr_ack_q, wr_ack_d;
  logic                         frame_tick_q, frame_tick_d;

  logic                         digit_last;
  logic                         frame_edge;

  assign digit_last = (cnt_q == '0);
  assign frame_edge = digit_last && (ptr_q == 2'd3);

  always_comb begin
    cnt_d        = digit_last ? CNT_RELOAD : cnt_q - CNT_W'(1);
    ptr_d        = digit_last ? ptr_q + 2'd1 : ptr_q;

    shadow_val_d = shadow_val_q;
    shadow_dot_d = shadow_dot_q;
    if (wr_en_i) begin
      shadow_val_d[wr_addr_i] = digit_data_i;
      shadow_dot_d[wr_addr_i] = dot_data_i;
    end

    // The copy reads the registered shadow, so a write landing on the copy
    // edge stays in shadow only and waits for the next commit.
    active_val_d = active_val_q;
    active_dot_d = active_dot_q;
    if (frame_edge && (pending_q || commit_i)) begin
      active_val_d = shadow_val_q;
      active_dot_d = shadow_dot_q;
    end

    // A commit arriving on the frame edge is served at once and never pends.
    if (frame_edge)    pending_d = 1'b0;
    else if (commit_i) pending_d = 1'b1;
    else               pending_d = pending_q;

    wr_ack_d     = wr_en_i;
    frame_tick_d = frame_edge;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= CNT_RELOAD;
      ptr_q        <= 2'd0;
      shadow_val_q <= '0;
      shadow_dot_q <= '1;
      active_val_q <= '0;
      active_dot_q <= '1;
      pending_q    <= 1'b0;
      wr_ack_q     <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      shadow_val_q <= shadow_val_d;
      shadow_dot_q <= shadow_dot_d;
      active_val_q <= active_val_d;
      active_dot_q <= active_dot_d;
      pending_q    <= pending_d;
      wr_ack_q     <= wr_ack_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign segment_o        = ptr_q;
  assign binary_o         = active_val_q[ptr_q];
  assign dot_o            = active_dot_q[ptr_q];
  assign wr_ack_o         = wr_ack_q;
  assign commit_pending_o = pending_q;
  assign frame_tick_o     = frame_tick_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
module tb_display_scan_scheduler;

  localparam int DW = 4;

  typedef struct packed {
    logic [3:0][3:0] val;
    logic [3:0]      dot;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [DW-1:0] digit_data;
  logic          dot_data;
  logic          commit;
  logic          wr_ack_o, commit_pending_o, frame_tick_o, dot_o;
  logic [DW-1:0] binary_o;
  logic [1:0]    segment_o;

  int checks = 0;
  int errors = 0;
  int cyc;
  bit mon_en = 1'b0;
  int     ack_q[$];
  frame_t frame_q[$];

  display_scan_scheduler #(.DATA_W(DW), .REFRESH_DIV(4), .CNT_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .digit_data_i(digit_data), .dot_data_i(dot_data), .commit_i(commit),
    .wr_ack_o(wr_ack_o), .commit_pending_o(commit_pending_o),
    .frame_tick_o(frame_tick_o), .binary_o(binary_o), .segment_o(segment_o),
    .dot_o(dot_o)
  );

  always #5 clk = ~clk;

  // Posedges since the last reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic frame_t mk_frame(input logic [3:0] v0, input logic [3:0] v1,
                                      input logic [3:0] v2, input logic [3:0] v3,
                                      input logic [3:0] dots);
    frame_t f;
    f.val[0] = v0; f.val[1] = v1; f.val[2] = v2; f.val[3] = v3;
    f.dot = dots;
    return f;
  endfunction

  task automatic to_cycle(input int p);
    while (cyc < p) @(negedge clk);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [3:0] d, input logic dt);
    wr_en = 1'b1; wr_addr = a; digit_data = d; dot_data = dt;
    ack_q.push_back(cyc + 1);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Ack monitor: each ack must land exactly on the cycle the scoreboard expects.
  initial forever begin
    @(posedge clk); #1;
    if (mon_en && rst_n && wr_ack_o) begin
      if (ack_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ack_unexpected actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        check("ack_cycle", cyc, ack_q.pop_front());
      end
    end
  end

  // Frame monitor: each frame tick opens a 16-cycle frame compared cell by cell.
  initial forever begin
    @(posedge clk); #1;
    if (mon_en && rst_n && frame_tick_o) begin
      if (frame_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame_unexpected actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        frame_t f;
        f = frame_q.pop_front();
        for (int i = 0; i < 16; i++) begin
          if (i > 0) begin @(posedge clk); #1; end
          if (!mon_en || !rst_n) break;
          check("frm_segment", int'(segment_o), i / 4);
          check("frm_binary", int'(binary_o), int'(f.val[i/4]));
          check("frm_dot", int'(dot_o), int'(f.dot[i/4]));
          check("frm_tick", int'(frame_tick_o), (i == 0) ? 1 : 0);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; digit_data = '0;
    dot_data = 1'b0; commit = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_binary", int'(binary_o), 0);
    check("rst_segment", int'(segment_o), 0);
    check("rst_dot", int'(dot_o), 1);
    check("rst_ack", int'(wr_ack_o), 0);
    check("rst_pending", int'(commit_pending_o), 0);
    check("rst_tick", int'(frame_tick_o), 0);

    // Test 1: free-running scan with reset contents.
    for (int k = 0; k < 3; k++) frame_q.push_back(mk_frame(0, 0, 0, 0, 4'b1111));
    mon_en = 1'b1;
    rst_n  = 1'b1;
    for (int p = 0; p < 16; p++) begin
      to_cycle(p);
      check("f0_segment", int'(segment_o), p / 4);
      check("f0_binary", int'(binary_o), 0);
      check("f0_dot", int'(dot_o), 1);
      check("f0_tick", int'(frame_tick_o), 0);
    end

    // Test 2: back-to-back writes into shadow only.
    to_cycle(16);
    do_write(2'd0, 4'h1, 1'b1);
    do_write(2'd1, 4'h2, 1'b1);
    do_write(2'd2, 4'h3, 1'b0);
    do_write(2'd3, 4'h4, 1'b1);

    // Test 3: commit mid-frame 3, copied at the edge at cycle 64.
    to_cycle(53);
    check("pre_commit_pending", int'(commit_pending_o), 0);
    commit = 1'b1;
    frame_q.push_back(mk_frame(4'h1, 4'h2, 4'h3, 4'h4, 4'b1011));
    @(negedge clk);
    commit = 1'b0;
    check("pending_set", int'(commit_pending_o), 1);
    to_cycle(58);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    to_cycle(63);
    check("pending_hold", int'(commit_pending_o), 1);
    to_cycle(64);
    check("pending_clear", int'(commit_pending_o), 0);

    // Test 4: commit and write addr0 on the frame edge at cycle 80.
    to_cycle(79);
    wr_en = 1'b1; wr_addr = 2'd0; digit_data = 4'h9; dot_data = 1'b1;
    commit = 1'b1;
    ack_q.push_back(cyc + 1);
    frame_q.push_back(mk_frame(4'h1, 4'h2, 4'h3, 4'h4, 4'b1011));
    frame_q.push_back(mk_frame(4'h1, 4'h2, 4'h3, 4'h4, 4'b1011));
    @(negedge clk);
    wr_en = 1'b0; commit = 1'b0;
    check("edge_commit_no_pending", int'(commit_pending_o), 0);
    to_cycle(99);
    commit = 1'b1;
    frame_q.push_back(mk_frame(4'h9, 4'h2, 4'h3, 4'h4, 4'b1011));
    frame_q.push_back(mk_frame(4'h9, 4'h2, 4'h3, 4'h4, 4'b1011));
    @(negedge clk);
    commit = 1'b0;
    check("second_pending", int'(commit_pending_o), 1);
    to_cycle(112);
    check("second_clear", int'(commit_pending_o), 0);

    // Test 5: reset mid-frame 8 with a commit pending.
    to_cycle(130);
    do_write(2'd1, 4'h7, 1'b0);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    to_cycle(135);
    check("t5_pending", int'(commit_pending_o), 1);
    to_cycle(137);
    mon_en = 1'b0;
    check("t5_pre_binary", int'(binary_o), 3);
    check("t5_pre_segment", int'(segment_o), 2);
    check("frames_left_pre", frame_q.size(), 0);
    check("acks_left_pre", ack_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_binary", int'(binary_o), 0);
    check("mid_rst_segment", int'(segment_o), 0);
    check("mid_rst_dot", int'(dot_o), 1);
    check("mid_rst_pending", int'(commit_pending_o), 0);
    check("mid_rst_ack", int'(wr_ack_o), 0);
    check("mid_rst_tick", int'(frame_tick_o), 0);
    @(negedge clk);
    frame_q.push_back(mk_frame(0, 0, 0, 0, 4'b1111));
    frame_q.push_back(mk_frame(0, 0, 0, 0, 4'b1111));
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int p = 0; p < 8; p++) begin
      to_cycle(p);
      check("restart_segment", int'(segment_o), p / 4);
      check("restart_pending", int'(commit_pending_o), 0);
    end
    to_cycle(47);
    mon_en = 1'b0;
    check("frames_left_end", frame_q.size(), 0);
    check("acks_left_end", ack_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
